// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative RV32M multiply/divide (shift-add / restoring divide)
//            that stalls the pipeline until the result is ready.
//            Optional early-out build: define MULDIV_FASTPATH_EN.
// Revision : 1.0
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_funct3;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_opa_raw;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_ovf;
    logic               r_mul_zero;

    logic               w_accept;
    logic               w_is_div;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic               w_div0;
    logic               w_ovf;
    logic               w_mul_zero;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_diff;

    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_fix_val;

    // Operand decode at accept; b is signed only for MULH/DIV/REM
    assign w_accept   = (r_state == c_IDLE) && start && !flush;
    assign w_is_div   = funct3[2];
    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_a_neg    = w_a_signed && op_a[WIDTH-1];
    assign w_b_neg    = w_b_signed && op_b[WIDTH-1];
    assign w_a_abs    = w_a_neg ? -op_a : op_a;
    assign w_b_abs    = w_b_neg ? -op_b : op_b;
    assign w_div0     = w_is_div && (op_b == '0);
    assign w_ovf      = w_is_div && !funct3[0] && (op_a == c_MOST_NEG) && (op_b == '1);
    assign w_mul_zero = !w_is_div && ((op_a == '0) || (op_b == '0));

    // One iteration of each datapath
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_mul_step = r_prod[0] ? {w_mul_sum, r_prod[WIDTH-1:1]}
                                  : {1'b0, r_prod[2*WIDTH-1:1]};
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_b};

    assign busy  = (r_state != c_IDLE);
    assign done  = (r_state == c_DONE);
    assign stall = ((r_state != c_IDLE) && (r_state != c_DONE)) || w_accept;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
`ifdef MULDIV_FASTPATH_EN
                    w_next = (w_div0 || w_ovf || w_mul_zero) ? c_FIX : c_CALC;
`else
                    w_next = c_CALC;
`endif
                end
            end
            c_CALC: begin
                if (flush)               w_next = c_IDLE;
                else if (r_cnt == c_LAST) w_next = c_FIX;
            end
            c_FIX:   w_next = flush ? c_IDLE : c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Sign correction and result selection; special cases override the datapath
    always_comb begin
        w_prod_fix = r_neg_q ? -r_prod : r_prod;
        w_quo_fix  = r_neg_q ? -r_quo  : r_quo;
        w_rem_fix  = r_neg_r ? -r_rem  : r_rem;
        w_fix_val  = '0;
        case (r_funct3)
            3'b000:                 w_fix_val = w_prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_fix_val = w_prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_fix_val = r_div0 ? '1 : (r_ovf ? c_MOST_NEG : w_quo_fix);
            default:                w_fix_val = r_div0 ? r_opa_raw : (r_ovf ? '0 : w_rem_fix);
        endcase
        if (r_mul_zero) w_fix_val = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_funct3   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_opa_raw  <= '0;
            r_prod     <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
            r_mul_zero <= 1'b0;
            result     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_funct3   <= funct3;
                        r_a        <= w_a_abs;
                        r_b        <= w_b_abs;
                        r_opa_raw  <= op_a;
                        r_prod     <= {{WIDTH{1'b0}}, w_b_abs};
                        r_rem      <= '0;
                        r_quo      <= w_a_abs;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div0     <= w_div0;
                        r_ovf      <= w_ovf;
                        r_mul_zero <= w_mul_zero;
                        r_cnt      <= '0;
                    end
                end
                c_CALC: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_funct3[2]) begin
                        r_rem <= w_rem_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_rem_diff[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], ~w_rem_diff[WIDTH]};
                    end else begin
                        r_prod <= w_mul_step;
                    end
                end
                c_FIX: begin
                    if (!flush) result <= w_fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
